// File: rtl/pll_cfg_serial_loader.sv
// Serial-to-parallel loader for the PLL register bank: address + data frames -> load strobe.
// Define PLL_CFG_PARITY_EN to add a trailing even-parity bit to every frame.
module pll_cfg_serial_loader #(
    parameter int DATA_W = 43,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_en,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              load_data,
    output logic [ADDR_W-1:0] select_reg,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              frame_err,
    output logic [7:0]        load_count
);

`ifdef PLL_CFG_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int L = ADDR_W + DATA_W + PAR_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        DONE
    } state_t;

    state_t           state;
    logic [L-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic             overrun;
    logic             accept;
    logic             parity_ok;

    assign accept = frame_en & bit_valid;
    assign busy   = (state != IDLE);

`ifdef PLL_CFG_PARITY_EN
    assign parity_ok = ~^shreg;
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            overrun    <= 1'b0;
            load_data  <= 1'b0;
            select_reg <= '0;
            data_out   <= '0;
            frame_err  <= 1'b0;
            load_count <= '0;
        end else begin
            load_data <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_en) begin
                        state   <= SHIFT;
                        overrun <= 1'b0;
                        // a bit arriving with the frame start is bit 0
                        if (bit_valid) begin
                            shreg <= {shreg[L-2:0], bit_in};
                            cnt   <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (!frame_en) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (bit_valid) begin
                        shreg <= {shreg[L-2:0], bit_in};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(L - 1)) begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    state   <= DONE;
                    overrun <= accept;
                    if (parity_ok) begin
                        load_data  <= 1'b1;
                        select_reg <= shreg[PAR_W+DATA_W +: ADDR_W];
                        data_out   <= shreg[PAR_W +: DATA_W];
                        load_count <= load_count + 8'd1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                DONE: begin
                    if (!frame_en) begin
                        frame_err <= overrun;
                        overrun   <= 1'b0;
                        state     <= IDLE;
                    end else if (bit_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_cfg_serial_loader.sv
// Randomised and directed bench for pll_cfg_serial_loader against a frame-level model.
// Build with PLL_CFG_PARITY_EN defined to exercise the parity variant.
module tb_pll_cfg_serial_loader;

    localparam int DW = 43;
    localparam int AW = 2;
`ifdef PLL_CFG_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L = AW + DW + P;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_en = 1'b0;
    logic          bit_valid = 1'b0;
    logic          bit_in = 1'b0;
    logic          load_data;
    logic [AW-1:0] select_reg;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          frame_err;
    logic [7:0]    load_count;

    pll_cfg_serial_loader dut (
        .clk        (clk),
        .rst        (rst),
        .frame_en   (frame_en),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .load_data  (load_data),
        .select_reg (select_reg),
        .data_out   (data_out),
        .busy       (busy),
        .frame_err  (frame_err),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_load = 0;
    int n_err = 0;
    int last_load_cyc = 0;

    // frame-level model: bits collected so far and what has happened to the frame
    bit            m_active, m_full, m_loaded, m_extra;
    bit            m_bits[$];
    logic [AW-1:0] m_sel;
    logic [DW-1:0] m_data;
    logic [7:0]    m_cnt;
    bit            m_load, m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_full = 0; m_loaded = 0; m_extra = 0;
        m_bits = {};
        m_sel = '0; m_data = '0; m_cnt = '0;
        m_load = 0; m_err = 0;
    endtask

    task automatic model_step(input bit fe, input bit bv, input bit bi);
        logic [63:0] v;
        m_load = 0;
        m_err = 0;
        if (m_full) begin
            v = '0;
            foreach (m_bits[i]) v = {v[62:0], m_bits[i]};
            if (P == 1 && (^v) == 1'b1) begin
                m_err = 1;
            end else begin
                m_load = 1;
                m_sel = v[P+DW +: AW];
                m_data = v[P +: DW];
                m_cnt = m_cnt + 8'd1;
            end
            m_full = 0;
            m_loaded = 1;
            m_extra = fe && bv;
        end else if (!m_active) begin
            if (fe) begin
                m_active = 1;
                m_bits = {};
                if (bv) m_bits.push_back(bi);
            end
        end else if (!m_loaded) begin
            if (!fe) begin
                m_err = 1;
                m_active = 0;
            end else if (bv) begin
                m_bits.push_back(bi);
                if (m_bits.size() == L) m_full = 1;
            end
        end else begin
            if (!fe) begin
                m_err = m_extra;
                m_active = 0;
                m_loaded = 0;
            end else if (bv) begin
                m_extra = 1;
            end
        end
    endtask

    task automatic cycle(input bit fe, input bit bv, input bit bi);
        frame_en = fe;
        bit_valid = bv;
        bit_in = bi;
        @(posedge clk);
        model_step(fe, bv, bi);
        @(negedge clk);
        cyc++;
        if (load_data === 1'b1) begin
            n_load++;
            last_load_cyc = cyc;
        end
        if (frame_err === 1'b1) n_err++;
        chk("load_data", 64'(load_data), 64'(m_load));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("busy", 64'(busy), 64'(m_active));
        chk("select_reg", 64'(select_reg), 64'(m_sel));
        chk("data_out", 64'(data_out), 64'(m_data));
        chk("load_count", 64'(load_count), 64'(m_cnt));
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_load", 64'(load_data), 64'd0);
        chk("rst_sel", 64'(select_reg), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(frame_err), 64'd0);
        chk("rst_cnt", 64'(load_count), 64'd0);
        model_reset();
        frame_en = 0;
        bit_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // sends nbits of the frame (extra bits beyond L are random), one bit every gap cycles
    task automatic send_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int nbits, input int gap, input bit flip,
                              output int start);
        logic [63:0] w;
        int sent;
        int slot;
        bit bv, bi;
        w = 64'({a, d});
        if (P == 1) w = {w[62:0], ^w[AW+DW-1:0]};
        if (flip) w[7] = ~w[7];
        sent = 0;
        slot = 0;
        start = cyc + 1;
        while (sent < nbits) begin
            bv = (slot % gap) == 0;
            bi = (sent < L) ? w[L-1-sent] : 1'($urandom);
            cycle(1, bv, bv ? bi : 1'($urandom));
            if (bv) sent++;
            slot++;
        end
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
    endtask

    initial begin
        int st, l0, e0;
        logic [DW-1:0] rd;
        model_reset();
        @(negedge clk);
        do_reset();

        // basic frame, a bit every cycle
        l0 = n_load; e0 = n_err;
        send_frame(2'b10, 43'h123_4567_89AB, L, 1, 0, st);
        chk("f1_loads", 64'(n_load - l0), 64'd1);
        chk("f1_latency", 64'(last_load_cyc - st), 64'(L));
        chk("f1_sel", 64'(select_reg), 64'd2);
        chk("f1_data", 64'(data_out), 64'h123_4567_89AB);
        chk("f1_cnt", 64'(load_count), 64'd1);

        // sparse bits, then an all-ones word
        send_frame(2'b10, 43'h123_4567_89AB, L, 3, 0, st);
        chk("f2_cnt", 64'(load_count), 64'd2);
        send_frame(2'b00, 43'h7FF_FFFF_FFFF, L, 1, 0, st);
        chk("f3_sel", 64'(select_reg), 64'd0);
        chk("f3_data", 64'(data_out), 64'h7FF_FFFF_FFFF);
        chk("f3_cnt", 64'(load_count), 64'd3);

        // abort after 20 bits
        l0 = n_load; e0 = n_err;
        send_frame(2'b11, 43'h0AA_5555_1234, 20, 1, 0, st);
        chk("ab_loads", 64'(n_load - l0), 64'd0);
        chk("ab_errs", 64'(n_err - e0), 64'd1);
        chk("ab_data", 64'(data_out), 64'h7FF_FFFF_FFFF);
        chk("ab_busy", 64'(busy), 64'd0);

        // overrun: two bits too many
        l0 = n_load; e0 = n_err;
        send_frame(2'b01, 43'h055_AAAA_0F0F, L + 2, 1, 0, st);
        chk("ov_loads", 64'(n_load - l0), 64'd1);
        chk("ov_errs", 64'(n_err - e0), 64'd1);
        chk("ov_sel", 64'(select_reg), 64'd1);
        chk("ov_data", 64'(data_out), 64'h055_AAAA_0F0F);
        chk("ov_cnt", 64'(load_count), 64'd4);

`ifdef PLL_CFG_PARITY_EN
        l0 = n_load; e0 = n_err;
        send_frame(2'b11, 43'h321_0FED_CBA9, L, 1, 1, st);
        chk("par_loads", 64'(n_load - l0), 64'd0);
        chk("par_errs", 64'(n_err - e0), 64'd1);
        chk("par_cnt", 64'(load_count), 64'd4);
        send_frame(2'b11, 43'h321_0FED_CBA9, L, 1, 0, st);
        chk("par_ok_cnt", 64'(load_count), 64'd5);
`endif

        // reset in the middle of a frame
        for (int i = 0; i < 30; i++) cycle(1, 1, 1'($urandom));
        do_reset();
        send_frame(2'b10, 43'h1DE_ADBE_EF01, L, 1, 0, st);
        chk("pr_sel", 64'(select_reg), 64'd2);
        chk("pr_data", 64'(data_out), 64'h1DE_ADBE_EF01);
        chk("pr_cnt", 64'(load_count), 64'd1);

        // load counter wrap
        do_reset();
        l0 = n_load;
        for (int i = 0; i < 256; i++) begin
            rd = {11'($urandom), 32'($urandom)};
            send_frame(2'($urandom), rd, L, 1, 0, st);
        end
        chk("wrap_loads", 64'(n_load - l0), 64'd256);
        chk("wrap_cnt", 64'(load_count), 64'd0);

        // random frame_en envelopes and bit_valid patterns
        for (int s = 0; s < 60; s++) begin
            int len;
            len = int'($urandom_range(1, 110));
            for (int i = 0; i < len; i++) begin
                cycle(1, ($urandom_range(0, 3) != 0), 1'($urandom));
            end
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                cycle(0, 1'($urandom), 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
